// File: rtl/instr_mem_bank.sv
// Instruction memory bank with a registered fetch port and a program port.
// After reset the storage is swept to NOP_WORD before fetches and writes are accepted.
module instr_mem_bank #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 3,
    parameter int                DEPTH    = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_err,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              busy
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
    logic              busy_int;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  word_we;
    logic [DATA_W-1:0] word_wdata;

    logic              fetch_in_range;
    logic              wt_hit;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] fetch_word;

    logic              valid_reg, valid_next;
    logic [DATA_W-1:0] instr_reg, instr_next;
    logic              err_reg, err_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // CLEAR walks the counter across every implemented word, then parks in READY.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            S_CLEAR: begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_next   = S_READY;
                    clr_cnt_next = '0;
                end
            end
            S_READY: begin
                state_next = S_READY;
            end
            default: begin
                state_next   = S_CLEAR;
                clr_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        busy_int = 1'b0;
        if (state_reg == S_CLEAR) begin
            busy_int = 1'b1;
        end
    end

    // Out-of-range program addresses match no word enable and are dropped.
    assign word_wdata = busy_int ? NOP_WORD : prog_data;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
            assign word_we[gi] = busy_int ? (clr_cnt_reg == ADDR_W'(gi))
                                          : (prog_we && (prog_addr == ADDR_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (word_we[i]) begin
                mem[i] <= word_wdata;
            end
        end
    end

    always_comb begin
        rd_word = NOP_WORD;
        for (int i = 0; i < DEPTH; i++) begin
            if (fetch_addr == ADDR_W'(i)) begin
                rd_word = mem[i];
            end
        end
    end

    assign fetch_in_range = ({{(32-ADDR_W){1'b0}}, fetch_addr} < 32'(DEPTH));
    // Same-address write and fetch forwards the incoming word.
    assign wt_hit         = prog_we && (prog_addr == fetch_addr);
    assign fetch_word     = !fetch_in_range ? NOP_WORD :
                            wt_hit          ? prog_data : rd_word;

    always_comb begin
        valid_next = valid_reg;
        instr_next = instr_reg;
        err_next   = err_reg;
        if (busy_int) begin
            valid_next = 1'b0;
            instr_next = NOP_WORD;
            err_next   = 1'b0;
        end else if (!fetch_stall) begin
            if (fetch_req) begin
                valid_next = 1'b1;
                instr_next = fetch_word;
                err_next   = !fetch_in_range;
            end else begin
                valid_next = 1'b0;
                err_next   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            instr_reg <= NOP_WORD;
            err_reg   <= 1'b0;
        end else begin
            valid_reg <= valid_next;
            instr_reg <= instr_next;
            err_reg   <= err_next;
        end
    end

    assign fetch_valid = valid_reg;
    assign fetch_instr = instr_reg;
    assign fetch_err   = err_reg;
    assign busy        = busy_int;

endmodule

// File: doc/instr_mem_bank.md
INSTR_MEM_BANK -- requirements
Module: instr_mem_bank

Interface
REQ-001: Parameter DATA_W, default 16, instruction word width in bits.
REQ-002: Parameter ADDR_W, default 3, fetch/program address width in bits.
REQ-003: Parameter DEPTH, default 8, number of implemented words, 1 <= DEPTH <= 2**ADDR_W.
REQ-004: Parameter NOP_WORD, default all-zero DATA_W value, word returned on clear, error or reset.
REQ-005: clk  input  1  single clock; all state updates on rising edge.
REQ-006: rst_n  input  1  asynchronous, active-low reset.
REQ-007: fetch_req  input  1  fetch request, one per cycle.
REQ-008: fetch_addr  input  ADDR_W  word address of the fetch (the PC).
REQ-009: fetch_stall  input  1  downstream stall; freezes the output registers.
REQ-010: fetch_valid  output  1  fetch_instr holds a completed fetch.
REQ-011: fetch_instr  output  DATA_W  registered instruction word.
REQ-012: fetch_err  output  1  completed fetch addressed a location >= DEPTH.
REQ-013: prog_we  input  1  program-port write enable.
REQ-014: prog_addr  input  ADDR_W  program-port word address.
REQ-015: prog_data  input  DATA_W  program-port write data.
REQ-016: busy  output  1  block is in CLEAR; fetch and program ports ignored.

Function
REQ-017: The block shall have two states, CLEAR and READY.
REQ-018: CLEAR: write NOP_WORD to one location per cycle using an internal counter from 0 to DEPTH-1, then move to READY on the cycle after location DEPTH-1 is written; CLEAR lasts exactly DEPTH cycles.
REQ-019: In CLEAR: busy=1, fetch_valid=0, fetch_instr=NOP_WORD, fetch_err=0; fetch_req and prog_we have no effect.
REQ-020: READY: busy=0; remain in READY until reset.
REQ-021: Fetch latency: fetch_req sampled high at edge N with fetch_stall low shall produce fetch_valid=1 and the word at fetch_addr on fetch_instr after edge N, i.e. one-cycle latency.
REQ-022: fetch_req low with fetch_stall low shall set fetch_valid=0 at the next edge; fetch_instr keeps its last value.
REQ-023: fetch_stall high shall hold fetch_valid, fetch_instr and fetch_err unchanged, and the fetch request in that cycle shall be dropped, not queued.
REQ-024: Out-of-range fetch (fetch_addr >= DEPTH): fetch_valid=1, fetch_err=1, fetch_instr=NOP_WORD; fetch_err shall clear on the next completed in-range fetch or idle cycle.
REQ-025: Program write: prog_we high in READY with prog_addr < DEPTH shall update that location at the edge; prog_addr >= DEPTH shall be ignored silently.
REQ-026: Program writes shall proceed regardless of fetch_stall.
REQ-027: Simultaneous write and fetch to the same address in the same cycle shall return the new prog_data (write-through).
REQ-028: Simultaneous write and fetch to different addresses shall both complete in that cycle.
REQ-029: Memory contents shall not be changed by fetches; only CLEAR and program writes modify storage.

Reset
REQ-030: rst_n low, asynchronously and at any time including mid-CLEAR or mid-stall, shall force: state=CLEAR, clear counter=0, busy=1, fetch_valid=0, fetch_err=0, fetch_instr=NOP_WORD.
REQ-031: On deassertion of rst_n, CLEAR shall restart from location 0 and run the full DEPTH cycles; previously programmed contents are not retained.

Verification
REQ-032: Reset then idle, defaults -> busy=1 for exactly 8 cycles, then 0; fetch_valid=0 throughout; fetch at addr 5 afterward -> fetch_instr=0x0000, fetch_valid=1 one cycle later.
REQ-033: Program addr1=0x3002, addr2=0x1012, then fetch 1,2 back-to-back -> 0x3002 then 0x1012 on consecutive cycles, fetch_err=0.
REQ-034: Same cycle prog_we to addr3 with 0x2213 and fetch_req addr3 -> next cycle fetch_instr=0x2213.
REQ-035: DEPTH=6, ADDR_W=3: fetch addr 7 -> fetch_valid=1, fetch_err=1, fetch_instr=NOP_WORD; program addr 6 then clear DEPTH? no -> contents of addrs 0-5 unchanged.
REQ-036: After fetch of 0x3002, hold fetch_stall=1 for 3 cycles with fetch_req to addr2 -> fetch_instr stays 0x3002 and fetch_valid=1; after stall drops, fetch of addr2 completes one cycle later.
REQ-037: Assert rst_n low during CLEAR at count 4, then release -> busy=1 for a full 8 more cycles, and all locations read NOP_WORD, including ones programmed before reset.
